// File: rtl/agent.sv
// agent: one SIR epidemic cell; per-edge infection draws from a private 16-bit Galois LFSR.
// Latency: state visible one cycle after the deciding edge; no backpressure. Define AGENT_IMMUNITY_LOSS_EN for SIRS.
module agent #(
    parameter int unsigned INFECT_PROB   = 8,
    parameter int unsigned INFECT_CYCLES = 10,
    parameter int unsigned IMMUNE_CYCLES = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  neighbourEdges,
    output logic [3:0]  outputEdges,
    input  logic [15:0] seedValue,
    input  logic        loadSeed,
    input  logic [15:0] address,
    input  logic [1:0]  initState,
    input  logic        loadState,
    output logic [1:0]  currState
);

    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [4:0]  PROB_TH    = 5'(INFECT_PROB);
    localparam logic [7:0]  I_LAST     = 8'(INFECT_CYCLES - 1);
`ifdef AGENT_IMMUNITY_LOSS_EN
    localparam logic [7:0]  R_LAST     = 8'(IMMUNE_CYCLES - 1);
`endif

    if (INFECT_PROB > 16) begin : g_bad_prob
        $error("agent: INFECT_PROB must be in 0..16");
    end
    if (INFECT_CYCLES < 1 || INFECT_CYCLES > 255) begin : g_bad_icyc
        $error("agent: INFECT_CYCLES must be in 1..255");
    end
    if (IMMUNE_CYCLES < 1 || IMMUNE_CYCLES > 255) begin : g_bad_rcyc
        $error("agent: IMMUNE_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_S = 2'b00,
        ST_I = 2'b01,
        ST_R = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] seed_mix;
    logic [3:0]  hit;

    // Draws use the pre-step LFSR value, one nibble per neighbour edge.
    always_comb begin
        hit = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            hit[i] = neighbourEdges[i] && ({1'b0, lfsr_q[4*i +: 4]} < PROB_TH);
        end
    end

    always_comb begin
        seed_mix = seedValue ^ address;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        if (loadSeed) begin
            lfsr_d = (seed_mix == 16'h0000) ? LFSR_RESET : seed_mix;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (loadState) begin
            state_d = (initState == 2'b11) ? ST_S : state_t'(initState);
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_S: begin
                    if (|hit) begin
                        state_d = ST_I;
                        cnt_d   = 8'd0;
                    end
                end
                ST_I: begin
                    if (cnt_q == I_LAST) begin
                        state_d = ST_R;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_R: begin
`ifdef AGENT_IMMUNITY_LOSS_EN
                    if (cnt_q == R_LAST) begin
                        state_d = ST_S;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_d = ST_S;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_S;
            cnt_q   <= 8'd0;
            lfsr_q  <= LFSR_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign outputEdges = (state_q == ST_I) ? 4'b1111 : 4'b0000;
    assign currState   = state_q;

endmodule

// File: tb/tb_agent.sv
// Bench for agent: three instances (INFECT_PROB 8, 0, 16) on shared stimulus, checked against an SIR reference model.
module tb_agent;
    localparam int IC  = 10;
    localparam int IMC = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, loadSeed, loadState;
    logic [3:0]  nb;
    logic [15:0] seed, addr;
    logic [1:0]  init;
    logic [3:0]  oe0, oe1, oe2;
    logic [1:0]  cs0, cs1, cs2;

    agent #(.INFECT_PROB(8)) dut_p8 (
        .clk(clk), .reset(reset), .neighbourEdges(nb), .outputEdges(oe0),
        .seedValue(seed), .loadSeed(loadSeed), .address(addr),
        .initState(init), .loadState(loadState), .currState(cs0));
    agent #(.INFECT_PROB(0)) dut_p0 (
        .clk(clk), .reset(reset), .neighbourEdges(nb), .outputEdges(oe1),
        .seedValue(seed), .loadSeed(loadSeed), .address(addr),
        .initState(init), .loadState(loadState), .currState(cs1));
    agent #(.INFECT_PROB(16)) dut_p16 (
        .clk(clk), .reset(reset), .neighbourEdges(nb), .outputEdges(oe2),
        .seedValue(seed), .loadSeed(loadSeed), .address(addr),
        .initState(init), .loadState(loadState), .currState(cs2));

    int n_err = 0;
    int n_chk = 0;

    // Reference model: state 0=S 1=I 2=R, age = cycles already spent in the current timed state.
    logic [15:0] m_lfsr [3];
    int          m_st   [3];
    int          m_age  [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int prob_of(input int k);
        case (k)
            0:       return 8;
            1:       return 0;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] dut_lfsr(input int k);
        case (k)
            0:       return dut_p8.lfsr_q;
            1:       return dut_p0.lfsr_q;
            default: return dut_p16.lfsr_q;
        endcase
    endfunction

    function automatic logic [1:0] dut_cs(input int k);
        case (k)
            0:       return cs0;
            1:       return cs1;
            default: return cs2;
        endcase
    endfunction

    function automatic logic [3:0] dut_oe(input int k);
        case (k)
            0:       return oe0;
            1:       return oe1;
            default: return oe2;
        endcase
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] pre;
            logic [15:0] mix;
            bit          any_hit;
            pre     = m_lfsr[k];
            any_hit = 1'b0;
            for (int e = 0; e < 4; e++) begin
                if (nb[e] && (int'(pre[4*e +: 4]) < prob_of(k))) any_hit = 1'b1;
            end
            if (reset) begin
                m_lfsr[k] = 16'hACE1;
                m_st[k]   = 0;
                m_age[k]  = 0;
            end else begin
                if (loadSeed) begin
                    mix       = seed ^ addr;
                    m_lfsr[k] = (mix == 16'h0000) ? 16'hACE1 : mix;
                end else begin
                    m_lfsr[k] = pre[0] ? ((pre >> 1) ^ 16'hB400) : (pre >> 1);
                end
                if (loadState) begin
                    m_st[k]  = (init == 2'b11) ? 0 : int'(init);
                    m_age[k] = 0;
                end else if (m_st[k] == 0) begin
                    if (any_hit) begin
                        m_st[k]  = 1;
                        m_age[k] = 0;
                    end
                end else if (m_st[k] == 1) begin
                    m_age[k]++;
                    if (m_age[k] == IC) begin
                        m_st[k]  = 2;
                        m_age[k] = 0;
                    end
                end else begin
`ifdef AGENT_IMMUNITY_LOSS_EN
                    m_age[k]++;
                    if (m_age[k] == IMC) begin
                        m_st[k]  = 0;
                        m_age[k] = 0;
                    end
`endif
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("i%0d_state", k), 32'(dut_cs(k)), 32'(m_st[k]));
            check($sformatf("i%0d_edges", k), 32'(dut_oe(k)), (m_st[k] == 1) ? 32'hF : 32'h0);
            check($sformatf("i%0d_lfsr", k), 32'(dut_lfsr(k)), 32'(m_lfsr[k]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int cnt;

    initial begin
        reset = 1'b1; loadSeed = 1'b0; loadState = 1'b0;
        nb = 4'h0; seed = 16'h0; addr = 16'h0; init = 2'b00;
        tick();
        tick();
        reset = 1'b0;

        // Never-infect instance stays S under full neighbour pressure.
        nb = 4'hF;
        repeat (100) begin
            tick();
            check("p0_quiet", {28'd0, dut_cs(1), dut_oe(1)}, 32'h0);
        end

        // Single-cycle exposure with always-infect: I for exactly IC cycles, then R.
        do_reset();
        nb = 4'b0001;
        tick();
        check("p16_enter", 32'(cs2), 32'd1);
        nb = 4'h0;
        cnt = 1;
        repeat (15) begin
            tick();
            if (oe2 == 4'hF) cnt++;
        end
        check("p16_dwell", 32'(cnt), 32'(IC));
        check("p16_recovered", 32'(cs2), 32'd2);

        // Seed loading, including the all-zero fallback.
        loadSeed = 1'b1; seed = 16'h1234; addr = 16'h1234;
        tick();
        check("seed_zero", 32'(dut_p8.lfsr_q), 32'hACE1);
        seed = 16'h0001; addr = 16'h0000;
        tick();
        check("seed_one", 32'(dut_p8.lfsr_q), 32'h0001);
        loadSeed = 1'b0;
        tick();
        check("seed_step", 32'(dut_p8.lfsr_q), 32'hB400);

        // loadState: 11 loads as S; loading I restarts a full dwell.
        loadState = 1'b1; init = 2'b11;
        tick();
        check("init11", {26'd0, cs0, cs1, cs2}, 32'h0);
        init = 2'b01; nb = 4'hF;
        tick();
        check("load_i", 32'(cs2), 32'd1);
        loadState = 1'b0;
        cnt = 1;
        repeat (12) begin
            tick();
            if (cs2 == 2'b01) cnt++;
        end
        check("load_i_dwell", 32'(cnt), 32'(IC));

        // Reset during the 5th infected cycle aborts the infection.
        nb = 4'h0;
        do_reset();
        nb = 4'b0001;
        tick();
        nb = 4'h0;
        repeat (4) tick();
        check("mid_still_i", 32'(cs2), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state", 32'(cs2), 32'd0);
        check("abort_edges", 32'(oe2), 32'd0);
        check("abort_lfsr", 32'(dut_p16.lfsr_q), 32'hACE1);

        // Recovered is absorbing in the default build even with active neighbours.
        nb = 4'b0001;
        tick();
        nb = 4'hF;
        repeat (1000) tick();
`ifndef AGENT_IMMUNITY_LOSS_EN
        check("r_persist", 32'(cs2), 32'd2);
`endif

        // Randomised traffic.
        repeat (1500) begin
            reset     = ($urandom_range(0, 99) == 0);
            loadSeed  = ($urandom_range(0, 15) == 0);
            seed      = 16'($urandom);
            addr      = ($urandom_range(0, 3) == 0) ? seed : 16'($urandom);
            loadState = ($urandom_range(0, 19) == 0);
            init      = 2'($urandom);
            nb        = 4'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/agent.md
AGENT -- requirements
Module: agent

Interface
- REQ-001 Parameter INFECT_PROB, default 8, gives the per-edge infection threshold out of 16; 0 means never infect and 16 means always infect.
- REQ-002 Parameter INFECT_CYCLES, default 10, is the number of cycles an agent stays Infected (range 1..255).
- REQ-003 Parameter IMMUNE_CYCLES, default 20, is the number of cycles an agent stays Recovered (range 1..255); it is used only with IMMUNITY_LOSS_EN.
- REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
- REQ-005 Port reset, input, 1 bit: reset is synchronous and active-high.
- REQ-006 Port neighbourEdges, input, 4 bits: bit i high means neighbour i is transmitting infection this cycle.
- REQ-007 Port outputEdges, output, 4 bits: infection transmitted by this agent to neighbours 0..3.
- REQ-008 Port seedValue, input, 16 bits: RNG seed.
- REQ-009 Port loadSeed, input, 1 bit: loads the RNG seed.
- REQ-010 Port address, input, 16 bits: agent identifier, mixed into the seed.
- REQ-011 Port initState, input, 2 bits: state value to load.
- REQ-012 Port loadState, input, 1 bit: loads initState into the agent state.
- REQ-013 Port currState, output, 2 bits: current state; 00 = Susceptible (S), 01 = Infected (I), 10 = Recovered (R).

Function
- REQ-014 The RNG SHALL be a 16-bit Galois LFSR with tap mask 0xB400 that shifts right one step every cycle when not reset or seeded.
- REQ-015 loadSeed SHALL load lfsr <= seedValue XOR address; if that result is 0x0000, it SHALL load 0xACE1 instead.
- REQ-016 The LFSR priority SHALL be reset > loadSeed > step; loadState SHALL NOT affect the LFSR.
- REQ-017 The draw for edge i SHALL be nibble r_i = lfsr[4i+3:4i], using the current (pre-step) LFSR value; hit_i = neighbourEdges[i] AND (r_i < INFECT_PROB).
- REQ-018 State S: if any hit_i is high, next state is I with dwell counter = 0; otherwise the state stays S.
- REQ-019 State I: the dwell counter increments each cycle; when the counter equals INFECT_CYCLES-1, next state is R with counter = 0.
- REQ-020 After entry, currState SHALL read I for exactly INFECT_CYCLES cycles.
- REQ-021 State R SHALL be absorbing unless IMMUNITY_LOSS_EN is defined.
- REQ-022 neighbourEdges SHALL be ignored in states I and R.
- REQ-023 loadState SHALL set state <= initState and clear the dwell counter.
- REQ-024 An initState value of 11 SHALL load as S.
- REQ-025 loadState SHALL take priority over the normal transition in the same cycle.
- REQ-026 loadSeed and loadState asserted in the same cycle SHALL both take effect.
- REQ-027 outputEdges SHALL be combinational: 4'b1111 when the registered state is I, else 4'b0000.
- REQ-028 currState SHALL be driven directly from the state register, so the new state is visible one cycle after the deciding edge.
- REQ-029 The dwell counter SHALL be 8 bits wide, SHALL saturate-free compare with the parameter, and SHALL never wrap in a legal configuration.

Reset
- REQ-030 Reset SHALL set state = S, dwell counter = 0, lfsr = 0xACE1, and outputEdges = 0.
- REQ-031 Reset SHALL override loadSeed and loadState in the same cycle.
- REQ-032 Reset asserted mid-infection SHALL abort the infection; the agent SHALL be S on the next cycle.

Configuration
- REQ-033 Macro AGENT_IMMUNITY_LOSS_EN, when defined, SHALL make the dwell counter also count in R, and R SHALL go to S with counter = 0 when the counter equals IMMUNE_CYCLES-1 (SIRS behaviour).
- REQ-034 When AGENT_IMMUNITY_LOSS_EN is not defined, R SHALL be permanent, IMMUNE_CYCLES SHALL be unused, and no R-timer logic SHALL be synthesised.

Verification
- REQ-035 Reset, then neighbourEdges = 4'b1111 with INFECT_PROB = 0 for 100 cycles -> currState = 00 and outputEdges = 0 throughout.
- REQ-036 With INFECT_PROB = 16 and neighbourEdges = 4'b0001 for one cycle -> currState = 01 on the next cycle, outputEdges = 4'b1111 for exactly 10 cycles, then currState = 10 and outputEdges = 0.
- REQ-037 loadSeed with seedValue = 0x1234 and address = 0x1234 -> lfsr = 0xACE1; with seedValue = 0x0001 and address = 0 -> lfsr = 0x0001, and after one step lfsr = 0xB400.
- REQ-038 loadState = 1 with initState = 2'b11 -> currState = 00; loadState with initState = 01 while neighbours are active and INFECT_PROB = 16 -> currState = 01 with the dwell counter restarted at 0.
- REQ-039 Reset asserted on the 5th Infected cycle -> next cycle currState = 00, outputEdges = 0, lfsr = 0xACE1.
- REQ-040 With AGENT_IMMUNITY_LOSS_EN defined and IMMUNE_CYCLES = 20 -> R lasts exactly 20 cycles, then S; without the macro, R persists for 1000 cycles.
